sha256_stream_hasher: RTL and testbench

Parametrised SHA-256 engine that hashes a message of `NUM_OF_WORDS` 32-bit words held in the shared word-addressed test memory. It writes the 256-bit digest back to memory and also exposes it on a register port. Padding is generated in hardware for any legal length, and the engine processes as many 512-bit blocks as the length requires. Each block is fetched just before it is compressed, and the message schedule is computed on the fly in a rolling 16-word window. It replaces the fixed two-block, 20-word hasher in the memory-mapped hashing datapath.

---
 rtl/sha256_stream_hasher.sv | 184 ++++++++++++++++++
 tb/tb_sha256_stream_hasher.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_stream_hasher.sv
// SHA-256 engine hashing NUM_OF_WORDS words from a synchronous word-addressed memory.
// Padding is generated in hardware and the message schedule rolls through a 16-word window.
module sha256_stream_hasher #(
  parameter int NUM_OF_WORDS = 20,
  parameter int ADDR_W       = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] message_addr,
  input  logic [ADDR_W-1:0] output_addr,
  output logic              done,
  output logic              mem_clk,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data,
  output logic [255:0]      digest
);

  localparam int NB = (NUM_OF_WORDS + 2) / 16 + 1;
  localparam logic [31:0] LEN_WORDS = 32'(NUM_OF_WORDS);
  localparam logic [31:0] LEN_BITS  = 32'(NUM_OF_WORDS * 32);
  localparam logic [31:0] LAST_IDX  = 32'(16 * NB - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_COMPUTE = 3'd2;
  localparam logic [2:0] S_UPDATE  = 3'd3;
  localparam logic [2:0] S_WRITE   = 3'd4;

  localparam logic [0:7][31:0] H_INIT = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [0:63][31:0] K_TABLE = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  logic [2:0]        state;
  logic [6:0]        cnt;
  logic [8:0]        blk;
  logic [ADDR_W-1:0] msg_base;
  logic [ADDR_W-1:0] out_base;
  logic [0:7][31:0]  h_state;
  logic [0:7][31:0]  h_sum;
  logic [15:0][31:0] w;
  logic [31:0]       va, vb, vc, vd, ve, vf, vg, vh;
  logic [31:0]       load_idx;
  logic [31:0]       pad_word;
  logic [31:0]       w_next;
  logic [31:0]       t1;
  logic [31:0]       t2;
  logic              last_blk;

  assign mem_clk  = clk;
  assign done     = (state == S_IDLE);
  assign last_blk = (32'(blk) + 32'd1 == 32'(NB));
  assign load_idx = 32'({blk, 4'b0000}) + 32'(cnt) - 32'd1;
  assign h_sum    = {h_state[0] + va, h_state[1] + vb, h_state[2] + vc, h_state[3] + vd,
                     h_state[4] + ve, h_state[5] + vf, h_state[6] + vg, h_state[7] + vh};

  // Slot captured this cycle: fetched word, the 0x80 marker, the bit length, or zero.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    pad_word = 32'h0;
    if (load_idx < LEN_WORDS)       pad_word = mem_read_data;
    else if (load_idx == LEN_WORDS) pad_word = 32'h8000_0000;
    else if (load_idx == LAST_IDX)  pad_word = LEN_BITS;
  end

  // w[0] is W[t]; w_next is W[t+16], shifted in as W[t] retires.
  always_comb begin
    w_next = (rotr(w[14], 17) ^ rotr(w[14], 19) ^ (w[14] >> 10)) + w[9]
           + (rotr(w[1], 7) ^ rotr(w[1], 18) ^ (w[1] >> 3)) + w[0];
    t1 = vh + (rotr(ve, 6) ^ rotr(ve, 11) ^ rotr(ve, 25)) + ((ve & vf) ^ (~ve & vg))
       + K_TABLE[cnt[5:0]] + w[0];
    t2 = (rotr(va, 2) ^ rotr(va, 13) ^ rotr(va, 22)) + ((va & vb) ^ (va & vc) ^ (vb & vc));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      cnt            <= '0;
      blk            <= '0;
      msg_base       <= '0;
      out_base       <= '0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      digest         <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      case (state)
        S_IDLE: if (start) begin
          msg_base <= message_addr;
          out_base <= output_addr;
          blk      <= '0;
          cnt      <= '0;
          mem_addr <= message_addr;
          state    <= S_LOAD;
        end
        S_LOAD: begin
          if (cnt < 7'd15)
            mem_addr <= msg_base + ADDR_W'(32'({blk, 4'b0000}) + 32'(cnt) + 32'd1);
          if (cnt == 7'd16) begin
            cnt   <= '0;
            state <= S_COMPUTE;
          end else begin
            cnt <= cnt + 7'd1;
          end
        end
        S_COMPUTE: begin
          if (cnt == 7'd63) begin
            cnt   <= '0;
            state <= S_UPDATE;
          end else begin
            cnt <= cnt + 7'd1;
          end
        end
        S_UPDATE: begin
          if (last_blk) begin
            state          <= S_WRITE;
            digest         <= h_sum;
            mem_we         <= 1'b1;
            mem_addr       <= out_base;
            mem_write_data <= h_sum[0];
          end else begin
            state    <= S_LOAD;
            blk      <= blk + 9'd1;
            mem_addr <= msg_base + ADDR_W'(32'({blk + 9'd1, 4'b0000}));
          end
        end
        S_WRITE: begin
          if (cnt == 7'd7) begin
            cnt    <= '0;
            mem_we <= 1'b0;
            state  <= S_IDLE;
          end else begin
            cnt            <= cnt + 7'd1;
            mem_addr       <= out_base + ADDR_W'(32'(cnt) + 32'd1);
            mem_write_data <= h_state[cnt[2:0] + 3'd1];
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: hash state, working variables and schedule window are fully written before use, so they carry no reset.
  always_ff @(posedge clk) begin
    case (state)
      S_IDLE: if (start) h_state <= H_INIT;
      S_LOAD: begin
        if (cnt != 7'd0) w <= {pad_word, w[15:1]};
        if (cnt == 7'd16) {va, vb, vc, vd, ve, vf, vg, vh} <= h_state;
      end
      S_COMPUTE: begin
        vh <= vg;
        vg <= vf;
        vf <= ve;
        ve <= vd + t1;
        vd <= vc;
        vc <= vb;
        vb <= va;
        va <= t1 + t2;
        w  <= {w_next, w[15:1]};
      end
      S_UPDATE: h_state <= h_sum;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sha256_stream_hasher.sv
// Bench for sha256_stream_hasher: three instances (20, 13 and 14 words) with private memories,
// random messages, and a plain array-based SHA-256 reference.
module tb_sha256_stream_hasher;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [15:0] message_addr;
  logic [15:0] output_addr;
  logic        start_s     [3];
  logic        done_s      [3];
  logic        mem_clk_s   [3];
  logic        mem_we_s    [3];
  logic [15:0] mem_addr_s  [3];
  logic [31:0] mem_wdata_s [3];
  logic [31:0] rdata_s     [3];
  logic [255:0] digest_s   [3];

  logic [31:0] mem [0:2][0:65535];
  logic        tb_we;
  int          tb_sel;
  logic [15:0] tb_addr;
  logic [31:0] tb_data;

  logic [31:0] msg [0:4095];
  logic [15:0] wr_addr [16];
  logic [31:0] wr_data [16];
  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WG = (g == 0) ? 20 : ((g == 1) ? 13 : 14);
    sha256_stream_hasher #(.NUM_OF_WORDS(WG), .ADDR_W(16)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .start         (start_s[g]),
      .message_addr  (message_addr),
      .output_addr   (output_addr),
      .done          (done_s[g]),
      .mem_clk       (mem_clk_s[g]),
      .mem_we        (mem_we_s[g]),
      .mem_addr      (mem_addr_s[g]),
      .mem_write_data(mem_wdata_s[g]),
      .mem_read_data (rdata_s[g]),
      .digest        (digest_s[g])
    );
    always @(posedge clk) begin
      if (mem_we_s[g]) mem[g][mem_addr_s[g]] <= mem_wdata_s[g];
      else if (tb_we && tb_sel == g) mem[g][tb_addr] <= tb_data;
      rdata_s[g] <= mem[g][mem_addr_s[g]];
    end
  end

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    logic [63:0] y;
    y = {x, x} >> n;
    return y[31:0];
  endfunction

  // Straight SHA-256 over msg[0..nw-1]: explicit padded array, full 64-entry schedule.
  function automatic logic [255:0] sha_model(input int nw);
    logic [31:0] p [$];
    logic [31:0] hh [8];
    logic [31:0] w  [64];
    logic [31:0] v  [8];
    logic [31:0] t1, t2;
    int nb;
    nb = (nw + 2) / 16 + 1;
    for (int i = 0; i < 16 * nb; i++)
      p.push_back(i < nw ? msg[i] : (i == nw ? 32'h8000_0000 : (i == 16 * nb - 1 ? 32'(nw * 32) : 32'h0)));
    hh = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
           32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    for (int k = 0; k < nb; k++) begin
      for (int t = 0; t < 64; t++)
        w[t] = (t < 16) ? p[16 * k + t]
             : (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
               + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
      v = hh;
      for (int t = 0; t < 64; t++) begin
        t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
        t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
        for (int j = 7; j > 0; j--) v[j] = v[j-1];
        v[4] = v[4] + t1;
        v[0] = t1 + t2;
      end
      for (int j = 0; j < 8; j++) hh[j] = hh[j] + v[j];
    end
    return {hh[0], hh[1], hh[2], hh[3], hh[4], hh[5], hh[6], hh[7]};
  endfunction

  task automatic preload(input int g, input logic [15:0] base, input int nw, input int extra);
    for (int i = 0; i < nw + extra; i++) begin
      tb_data = $urandom;
      if (i < nw) msg[i] = tb_data;
      tb_sel  = g;
      tb_addr = 16'(base + 16'(i));
      tb_we   = 1'b1;
      @(posedge clk); #1;
    end
    tb_we = 1'b0;
  endtask

  task automatic launch(input int g);
    start_s[g] = 1'b1;
    @(posedge clk); #1;
    start_s[g] = 1'b0;
  endtask

  // Runs until done; cycles counted in edges after the start edge, -1 on timeout.
  task automatic wait_done(input int g, input int pulse_at, input bit keep,
                           output int cyc, output int n_we, output int first_we, output int last_we);
    int n = 0;
    n_we = 0; first_we = -1; last_we = -1; cyc = -1;
    while (n < 2000) begin
      @(posedge clk); #1;
      n++;
      if (!keep) start_s[g] = (n == pulse_at);
      if (mem_we_s[g]) begin
        if (first_we < 0) first_we = n;
        last_we = n;
        if (n_we < 16) begin
          wr_addr[n_we] = mem_addr_s[g];
          wr_data[n_we] = mem_wdata_s[g];
        end
        n_we++;
      end
      if (done_s[g]) begin
        cyc = n;
        break;
      end
    end
    if (!keep) start_s[g] = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; message_addr = '0; output_addr = '0; tb_we = 1'b0; tb_sel = 0;
    tb_addr = '0; tb_data = '0;
    for (int g = 0; g < 3; g++) start_s[g] = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    for (int g = 0; g < 3; g++) begin
      n_checks++;
      if (done_s[g] !== 1'b1) $display("FAIL reset_done[%0d]: got %b want 1", g, done_s[g]); else n_pass++;
      n_checks++;
      if (mem_we_s[g] !== 1'b0) $display("FAIL reset_we[%0d]: got %b want 0", g, mem_we_s[g]); else n_pass++;
      n_checks++;
      if (digest_s[g] !== 256'h0) $display("FAIL reset_digest[%0d]: got %h want 0", g, digest_s[g]); else n_pass++;
    end
    n_checks++;
    if (mem_addr_s[0] !== 16'h0) $display("FAIL reset_addr: got %h want 0", mem_addr_s[0]); else n_pass++;
    n_checks++;
    if (mem_wdata_s[0] !== 32'h0) $display("FAIL reset_wdata: got %h want 0", mem_wdata_s[0]); else n_pass++;
  endtask

  // Full single hash on instance g with timing, write-stream, memory and digest checks.
  task automatic test_hash(input string name, input int g, input int nw, input int extra,
                           input logic [15:0] ma, input logic [15:0] oa, input int pulse_at);
    logic [255:0] exp_d;
    int cyc, n_we, fw, lw, nb;
    nb = (nw + 2) / 16 + 1;
    message_addr = ma; output_addr = oa;
    preload(g, ma, nw, extra);
    exp_d = sha_model(nw);
    launch(g);
    n_checks++;
    if (done_s[g] !== 1'b0) $display("FAIL %s_busy: done=%b want 0", name, done_s[g]); else n_pass++;
    wait_done(g, pulse_at, 1'b0, cyc, n_we, fw, lw);
    n_checks++;
    if (cyc != 82 * nb + 8) $display("FAIL %s_cycles: got %0d want %0d", name, cyc, 82 * nb + 8); else n_pass++;
    n_checks++;
    if (n_we != 8 || fw != 82 * nb || lw != 82 * nb + 7)
      $display("FAIL %s_write_window: count %0d first %0d last %0d want 8 %0d %0d", name, n_we, fw, lw, 82 * nb, 82 * nb + 7);
    else n_pass++;
    n_checks++;
    if (digest_s[g] !== exp_d) $display("FAIL %s_digest: got %h want %h", name, digest_s[g], exp_d); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      logic [15:0] a_exp;
      logic [31:0] d_exp;
      a_exp = 16'(oa + 16'(i));
      d_exp = exp_d[255 - 32 * i -: 32];
      n_checks++;
      if (i >= n_we || wr_addr[i] !== a_exp || wr_data[i] !== d_exp || mem[g][a_exp] !== d_exp)
        $display("FAIL %s_write%0d: addr %h data %h mem %h want addr %h data %h", name, i,
                 wr_addr[i], wr_data[i], mem[g][a_exp], a_exp, d_exp);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic [255:0] exp_d;
    int cyc, n_we, fw, lw;
    message_addr = 16'h0300; output_addr = 16'h0900;
    preload(0, 16'h0300, 20, 0);
    exp_d = sha_model(20);
    launch(0);
    repeat (109) @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (done_s[0] !== 1'b1 || mem_we_s[0] !== 1'b0 || digest_s[0] !== 256'h0)
      $display("FAIL mid_reset: done %b we %b digest %h want 1 0 0", done_s[0], mem_we_s[0], digest_s[0]);
    else n_pass++;
    reset_n = 1'b1;
    @(posedge clk); #1;
    launch(0);
    wait_done(0, -1, 1'b0, cyc, n_we, fw, lw);
    n_checks++;
    if (cyc != 172 || digest_s[0] !== exp_d)
      $display("FAIL mid_reset_rerun: cycles %0d digest %h want 172 %h", cyc, digest_s[0], exp_d);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [255:0] exp_d;
    int cyc, n_we, fw, lw;
    message_addr = 16'h0400; output_addr = 16'h0a00;
    preload(0, 16'h0400, 20, 0);
    exp_d = sha_model(20);
    start_s[0] = 1'b1;
    @(posedge clk); #1;
    wait_done(0, -1, 1'b1, cyc, n_we, fw, lw);
    n_checks++;
    if (cyc != 172 || digest_s[0] !== exp_d)
      $display("FAIL b2b_first: cycles %0d digest %h want 172 %h", cyc, digest_s[0], exp_d);
    else n_pass++;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    n_checks++;
    if (done_s[0] !== 1'b0) $display("FAIL b2b_restart: done %b want 0", done_s[0]); else n_pass++;
    wait_done(0, -1, 1'b0, cyc, n_we, fw, lw);
    n_checks++;
    if (cyc != 172 || n_we != 8 || digest_s[0] !== exp_d)
      $display("FAIL b2b_second: cycles %0d writes %0d digest %h want 172 8 %h", cyc, n_we, digest_s[0], exp_d);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_hash("w20", 0, 20, 4, 16'h0100, 16'h0800, -1);
    test_hash("w13", 1, 13, 8, 16'h0200, 16'h0880, -1);
    test_hash("w14", 2, 14, 18, 16'h0240, 16'h08c0, -1);
    test_hash("wrap", 0, 20, 0, 16'hfff8, 16'hfffc, -1);
    test_hash("start_ignored", 0, 20, 0, 16'h0500, 16'h0b00, 30);
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
